// File: rtl/mash_ncl.sv
// mash_ncl: noise-cancellation network for a MASH fractional-N modulator.
// Combines skew-aligned accumulator carries into a signed output y and adds y
// to the integer ratio to form a saturated instantaneous divide value.
//
// Configuration macro: NCL_ORDER3_EN
//   defined   -> third order: y = c1(2*P_SKEW) + (1-z^-1)c2(P_SKEW) + (1-z^-1)^2 c3
//   undefined -> second order: y = c1(P_SKEW) + (1-z^-1)c2, i_c3 ignored
//
// Parameters: P_SKEW (1..4) carry skew per stage, P_INT_WIDTH (>=4) ratio width.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset (priority over i_en)
//   i_en     sample qualifier; all state advances only when high
//   i_c1..3  accumulator carries of stages 1..3
//   i_n_int  unsigned integer part of the division ratio
//   o_y      registered signed noise-cancelled output
//   o_div    registered saturated i_n_int + o_y
//   o_valid  high once the pipeline has been filled since reset
module mash_ncl #(
  parameter int unsigned P_SKEW      = 1,
  parameter int unsigned P_INT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_c1,
  input  logic                   i_c2,
  input  logic                   i_c3,
  input  logic [P_INT_WIDTH-1:0] i_n_int,
  output logic signed [3:0]      o_y,
  output logic [P_INT_WIDTH-1:0] o_div,
  output logic                   o_valid
);

`ifdef NCL_ORDER3_EN
  localparam int unsigned C1_LEN = 2 * P_SKEW;
  localparam int unsigned FILL   = 2 * P_SKEW + 2;
`else
  localparam int unsigned C1_LEN = P_SKEW;
  localparam int unsigned FILL   = P_SKEW + 1;
`endif
  localparam int unsigned CW = $clog2(FILL + 1);
  localparam int unsigned SW = P_INT_WIDTH + 2;

  // Zero-extend a carry bit into a 4-bit signed term.
  function automatic logic signed [3:0] f_ext(input logic b);
    return {3'b000, b};
  endfunction

  logic [C1_LEN-1:0]        r_c1_dl;   // index k = c1 delayed k+1 samples
  logic signed [3:0]        r_y;
  logic [P_INT_WIDTH-1:0]   r_div;
  logic                     r_valid;
  logic [CW-1:0]            r_fill;

  logic signed [3:0]        w_y;
  logic signed [SW-1:0]     w_sum;
  logic [P_INT_WIDTH-1:0]   w_div;

`ifdef NCL_ORDER3_EN
  // c2 line is one tap longer than the skew so the differentiator can see c2'[n-1].
  logic [P_SKEW:0]          r_c2_dl;
  logic [1:0]               r_c3_h;    // [0] = c3[n-1], [1] = c3[n-2]

  assign w_y = f_ext(r_c1_dl[C1_LEN-1])
             + f_ext(r_c2_dl[P_SKEW-1]) - f_ext(r_c2_dl[P_SKEW])
             + f_ext(i_c3) - f_ext(r_c3_h[0]) - f_ext(r_c3_h[0]) + f_ext(r_c3_h[1]);
`else
  logic                     r_c2_prev;
  logic                     w_unused_c3;

  assign w_unused_c3 = i_c3;
  assign w_y = f_ext(r_c1_dl[C1_LEN-1]) + f_ext(i_c2) - f_ext(r_c2_prev);
`endif

  // Ratio plus sign-extended y, two guard bits so neither direction wraps.
  assign w_sum = $signed({2'b00, i_n_int}) + $signed({{(SW-4){w_y[3]}}, w_y});

  // Clamp to the unsigned divider range.
  always_comb begin
    w_div = w_sum[P_INT_WIDTH-1:0];
    if (w_sum[SW-1]) begin
      w_div = '0;
    end else if (w_sum[P_INT_WIDTH]) begin
      w_div = '1;
    end
  end

  // Pipeline state, output registers and fill tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c1_dl <= '0;
`ifdef NCL_ORDER3_EN
      r_c2_dl <= '0;
      r_c3_h  <= '0;
`else
      r_c2_prev <= 1'b0;
`endif
      r_y     <= '0;
      r_div   <= '0;
      r_valid <= 1'b0;
      r_fill  <= '0;
    end else if (i_en) begin
      r_c1_dl[0] <= i_c1;
      for (int k = 1; k < int'(C1_LEN); k++) begin
        r_c1_dl[k] <= r_c1_dl[k-1];
      end
`ifdef NCL_ORDER3_EN
      r_c2_dl[0] <= i_c2;
      for (int k = 1; k <= int'(P_SKEW); k++) begin
        r_c2_dl[k] <= r_c2_dl[k-1];
      end
      r_c3_h <= {r_c3_h[0], i_c3};
`else
      r_c2_prev <= i_c2;
`endif
      r_y   <= w_y;
      r_div <= w_div;
      if (r_fill != CW'(FILL)) begin
        r_fill <= r_fill + CW'(1);
      end
      // The sample being taken now is number r_fill+1.
      if (r_fill >= CW'(FILL - 1)) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign o_y     = r_y;
  assign o_div   = r_div;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_mash_ncl.sv
module tb_mash_ncl;

  localparam int unsigned SKEW = 1;
  localparam int unsigned IW   = 8;
  localparam int MAXDIV = (1 << IW) - 1;
`ifdef NCL_ORDER3_EN
  localparam int FILL = 2 * SKEW + 2;
`else
  localparam int FILL = SKEW + 1;
`endif

  logic clk = 1'b0;
  logic rst, en, c1, c2, c3;
  logic [IW-1:0] n_int;
  logic signed [3:0] y;
  logic [IW-1:0] dv;
  logic valid;

  int n_cmp = 0;
  int n_err = 0;

  mash_ncl #(.P_SKEW(SKEW), .P_INT_WIDTH(IW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_c1(c1), .i_c2(c2), .i_c3(c3), .i_n_int(n_int),
    .o_y(y), .o_div(dv), .o_valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of enabled samples, newest at index 0.
  int hc1[$], hc2[$], hc3[$];
  int m_y = 0, m_div = 0, m_cnt = 0;
  bit m_valid = 1'b0, m_live = 1'b0;

  function automatic int g(input int q[$], input int k);
    return (k < q.size()) ? q[k] : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hc1.delete(); hc2.delete(); hc3.delete();
      m_cnt = 0; m_y = 0; m_div = 0; m_valid = 1'b0; m_live = 1'b1;
    end else if (en) begin
      int s;
      hc1.push_front(int'(c1)); hc2.push_front(int'(c2)); hc3.push_front(int'(c3));
      if (hc1.size() > 16) begin
        hc1.delete(16); hc2.delete(16); hc3.delete(16);
      end
`ifdef NCL_ORDER3_EN
      m_y = g(hc1, 2*SKEW) + g(hc2, SKEW) - g(hc2, SKEW+1)
          + g(hc3, 0) - 2*g(hc3, 1) + g(hc3, 2);
`else
      m_y = g(hc1, SKEW) + g(hc2, 0) - g(hc2, 1);
`endif
      s = int'(n_int) + m_y;
      m_div = (s < 0) ? 0 : (s > MAXDIV) ? MAXDIV : s;
      m_cnt++;
      if (m_cnt >= FILL) m_valid = 1'b1;
    end
  end

  // Every-cycle comparison against the model once reset has been seen.
  always @(negedge clk) begin
    if (m_live) begin
      chk("model_y", int'(y), m_y);
      chk("model_div", int'(dv), m_div);
      chk("model_valid", int'(valid), int'(m_valid));
    end
  end

  task automatic smp(input logic e, input logic a, input logic b, input logic c,
                     input int n);
    rst = 1'b0; en = e; c1 = a; c2 = b; c3 = c; n_int = IW'(n);
    @(negedge clk);
  endtask

  task automatic do_rst(input logic e);
    rst = 1'b1; en = e; c1 = 1'b1; c2 = 1'b1; c3 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0; n_int = '0;
    @(negedge clk);
    chk("rst_y", int'(y), 0);
    chk("rst_div", int'(dv), 0);
    chk("rst_valid", int'(valid), 0);
    @(negedge clk);

    // All carries high: valid after FILL samples, steady y=1, div=41.
    for (int i = 1; i <= 10; i++) begin
      smp(1, 1, 1, 1, 40);
      if (i == FILL - 1) chk("fill_pre_valid", int'(valid), 0);
      if (i == FILL)     chk("fill_valid", int'(valid), 1);
    end
    chk("steady_y", int'(y), 1);
    chk("steady_div", int'(dv), 41);

    // Single c3 pulse with a 5-cycle enable gap in the middle.
    do_rst(1'b1);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_div", int'(dv), 0);
    for (int i = 0; i < 4; i++) smp(1, 0, 0, 0, 40);
    smp(1, 0, 0, 1, 40);
`ifdef NCL_ORDER3_EN
    chk("pulse_y1", int'(y), 1);   chk("pulse_div1", int'(dv), 41);
`else
    chk("pulse_y1", int'(y), 0);   chk("pulse_div1", int'(dv), 40);
`endif
    smp(1, 0, 0, 0, 40);
    for (int i = 0; i < 5; i++) begin
      smp(0, 1, 1, 1, 99);
`ifdef NCL_ORDER3_EN
      chk("hold_y", int'(y), -2);  chk("hold_div", int'(dv), 38);
`else
      chk("hold_y", int'(y), 0);   chk("hold_div", int'(dv), 40);
`endif
      chk("hold_valid", int'(valid), 1);
    end
    smp(1, 0, 0, 0, 40);
`ifdef NCL_ORDER3_EN
    chk("pulse_y3", int'(y), 1);   chk("pulse_div3", int'(dv), 41);
`endif
    smp(1, 0, 0, 0, 40);
    chk("pulse_y4", int'(y), 0);   chk("pulse_div4", int'(dv), 40);

    // Saturation low (n=1) and high (n=254).
    do_rst(1'b0);
    for (int i = 0; i < 4; i++) smp(1, 0, 0, 0, 1);
    smp(1, 0, 0, 1, 1);
    smp(1, 0, 0, 0, 1);
`ifdef NCL_ORDER3_EN
    chk("sat_low", int'(dv), 0);
`else
    chk("sat_low", int'(dv), 1);
`endif
    smp(1, 0, 0, 0, 1);
    smp(1, 1, 0, 0, 254);
    smp(1, 1, 0, 0, 254);
    smp(1, 1, 0, 1, 254);
    chk("sat_high", int'(dv), 255);
    smp(1, 1, 0, 0, 254);
`ifdef NCL_ORDER3_EN
    chk("sat_after", int'(dv), 253);
`else
    chk("sat_after", int'(dv), 255);
`endif

    // c2 pulse while c3 toggles.
    do_rst(1'b0);
    for (int i = 0; i < 4; i++) smp(1, 0, 0, 1'(i), 40);
    smp(1, 0, 1, 0, 40);
`ifndef NCL_ORDER3_EN
    chk("c2_y1", int'(y), 1);
`endif
    smp(1, 0, 0, 1, 40);
`ifndef NCL_ORDER3_EN
    chk("c2_y2", int'(y), -1);
`endif
    smp(1, 0, 0, 0, 40);
`ifndef NCL_ORDER3_EN
    chk("c2_y3", int'(y), 0);
`endif

    // Pseudo-random traffic with occasional resets, checked by the model.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) do_rst(1'($urandom));
      else smp(1'(r > 25), 1'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 7)) < 2 ? int'($urandom_range(0, 3)) :
               int'($urandom_range(0, 7)) < 2 ? int'($urandom_range(252, 255)) :
               int'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
